// File: rtl/vec_store_serializer.sv
// -----------------------------------------------------------------------------
// vec_store_serializer
//
// Takes one 4-lane vector ALU result and stores it as a sequence of single
// byte writes: each enabled 32-bit lane is saturated to an unsigned pixel byte
// and written to base address + lane index. Lanes go out lowest index first.
//
// Ports
//   clk, rst        single clock, synchronous active-high reset
//   in_valid        a vector is offered
//   in_ready        block can accept a vector (only in IDLE)
//   in_data         lane i = in_data[32i+31:32i]
//   in_addr         byte address of lane 0
//   in_mask         lane write enables, bit i enables lane i
//   mem_we          byte write request
//   mem_addr        byte address of the current write
//   mem_wdata       saturated pixel byte of the current write
//   mem_ready       memory accepts the write this cycle
//   busy            high while a vector is held (WRITE and DONE)
//   done            one-cycle pulse once all writes of a vector are done
//   state_dbg       current FSM state, for observation
//
// Handshakes (both sides use the same valid/ready rule):
//   A transfer happens on a rising edge where valid and ready are both high.
//   The producer holds its payload stable while valid is high and ready is
//   low. Input side: in_valid/in_ready. Memory side: mem_we acts as valid and
//   mem_ready as ready; mem_addr/mem_wdata hold until the write is taken.
//
// All memory-side outputs, busy and done are flops; nothing reaches an output
// combinationally from in_valid or mem_ready.
// -----------------------------------------------------------------------------
module vec_store_serializer #(
  parameter int ADDR_W = 32,
  parameter int LANES  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [32*LANES-1:0] in_data,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [LANES-1:0]    in_mask,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [7:0]          mem_wdata,
  input  logic                mem_ready,
  output logic                busy,
  output logic                done,
  output logic [1:0]          state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state;
  logic [32*LANES-1:0]   data_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [LANES-1:0]      mask_q;
  logic [1:0]            lane_q;

  // Next-write selection. The output flops are loaded one cycle ahead, so the
  // selection looks at the incoming vector while IDLE and at the mask with the
  // current lane already retired while WRITE.
  logic [LANES-1:0]      rem_mask;
  logic [LANES-1:0]      src_mask;
  logic [32*LANES-1:0]   src_data;
  logic [ADDR_W-1:0]     src_addr;
  logic [1:0]            nxt_lane;
  logic [31:0]           nxt_word;
  logic [ADDR_W-1:0]     nxt_addr;
  logic [7:0]            nxt_wdata;

  // Lowest-index set bit; 0 when the mask is empty (caller never uses it then).
  function automatic logic [1:0] first_lane(input logic [LANES-1:0] m);
    logic [1:0] l;
    l = 2'd0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (m[i]) l = i[1:0];
    end
    return l;
  endfunction

  // Unsigned saturation of a 32-bit lane to a pixel byte.
  function automatic logic [7:0] sat8(input logic [31:0] v);
    return (v > 32'd255) ? 8'hFF : v[7:0];
  endfunction

  always_comb begin
    rem_mask = mask_q & ~(LANES'(1) << lane_q);
    if (state == IDLE) begin
      src_mask = in_mask;
      src_data = in_data;
      src_addr = in_addr;
    end else begin
      src_mask = rem_mask;
      src_data = data_q;
      src_addr = addr_q;
    end
    nxt_lane  = first_lane(src_mask);
    nxt_word  = src_data[32*nxt_lane +: 32];
    // Address arithmetic wraps naturally at ADDR_W bits.
    nxt_addr  = src_addr + {{(ADDR_W-2){1'b0}}, nxt_lane};
    nxt_wdata = sat8(nxt_word);
  end

  assign in_ready  = (state == IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      // Reset also aborts any vector in flight: pending lanes are dropped and
      // no done pulse follows.
      state     <= IDLE;
      data_q    <= '0;
      addr_q    <= '0;
      mask_q    <= '0;
      lane_q    <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (in_valid) begin
            data_q <= in_data;
            addr_q <= in_addr;
            mask_q <= in_mask;
            busy   <= 1'b1;
            if (in_mask != '0) begin
              state     <= WRITE;
              lane_q    <= nxt_lane;
              mem_we    <= 1'b1;
              mem_addr  <= nxt_addr;
              mem_wdata <= nxt_wdata;
            end else begin
              // Empty mask: nothing to write, report completion directly.
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end

        WRITE: begin
          // Without mem_ready everything holds, keeping the write stable.
          if (mem_ready) begin
            mask_q <= rem_mask;
            if (rem_mask == '0) begin
              state     <= DONE;
              done      <= 1'b1;
              mem_we    <= 1'b0;
              mem_addr  <= '0;
              mem_wdata <= '0;
            end else begin
              lane_q    <= nxt_lane;
              mem_addr  <= nxt_addr;
              mem_wdata <= nxt_wdata;
            end
          end
        end

        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: begin
          state     <= IDLE;
          mem_we    <= 1'b0;
          mem_addr  <= '0;
          mem_wdata <= '0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vec_store_serializer.sv
module tb_vec_store_serializer;

  localparam int ADDR_W = 32;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [127:0]      in_data;
  logic [ADDR_W-1:0] in_addr;
  logic [3:0]        in_mask;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_ready;
  logic              busy;
  logic              done;
  logic [1:0]        state_dbg;

  vec_store_serializer #(.ADDR_W(ADDR_W), .LANES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_addr   (in_addr),
    .in_mask   (in_mask),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: {addr, byte} of each expected write, in order.
  logic [ADDR_W+7:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [7:0] ref_sat(input logic [31:0] v);
    if (v > 32'd255) return 8'hFF;
    return v[7:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called with inputs already set for the current cycle (between negedge and
  // posedge): scores any write about to be accepted, then advances one cycle.
  task automatic tick();
    logic [ADDR_W+7:0] e;
    if (mem_we === 1'b1 && mem_ready === 1'b1 && rst === 1'b0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {mem_addr, mem_wdata}, 64'hDEAD_BEEF);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", mem_addr, e[ADDR_W+7:8]);
        chk("wr_data", mem_wdata, e[7:0]);
      end
    end
    @(negedge clk);
  endtask

  task automatic push_vec(input logic [127:0] d, input logic [ADDR_W-1:0] a,
                          input logic [3:0] m);
    logic [ADDR_W-1:0] wa;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        wa = a + ADDR_W'(i);
        exp_q.push_back({wa, ref_sat(d[32*i +: 32])});
      end
    end
  endtask

  // Drives one vector for a single cycle; returns at cycle T+1.
  task automatic send(input logic [127:0] d, input logic [ADDR_W-1:0] a,
                      input logic [3:0] m);
    chk("send_in_ready", in_ready, 1'b1);
    in_data  = d;
    in_addr  = a;
    in_mask  = m;
    in_valid = 1'b1;
    push_vec(d, a, m);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    chk({tag, "_mem_we"}, mem_we, 1'b0);
    chk({tag, "_mem_addr"}, mem_addr, '0);
    chk({tag, "_mem_wdata"}, mem_wdata, 8'h00);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
  endtask

  logic [ADDR_W-1:0] h_addr;
  logic [7:0]        h_wdata;
  logic [127:0]      rd;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b1;   // must be ignored while in reset
    in_data   = {4{32'h0000_0011}};
    in_addr   = 32'h0000_0040;
    in_mask   = 4'b1111;
    mem_ready = 1'b1;
    @(negedge clk);
    tick();
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    chk_idle("reset");

    // Full vector, lane3..lane0 = 0, 2, 250, 255
    send({32'd0, 32'd2, 32'd250, 32'd255}, 32'h0000_0100, 4'b1111);
    for (int k = 1; k <= 4; k++) begin
      chk("full_we", mem_we, 1'b1);
      chk("full_busy", busy, 1'b1);
      tick();
    end
    chk("full_done", done, 1'b1);
    chk("full_we_off", mem_we, 1'b0);
    tick();
    chk_idle("full_after");

    // Saturation and mask
    send({32'hFFFF_FFFF, 32'd7, 32'd300, 32'd0}, 32'h0000_0200, 4'b0110);
    chk("sat_we1", mem_we, 1'b1);
    tick();
    chk("sat_we2", mem_we, 1'b1);
    tick();
    chk("sat_done", done, 1'b1);
    tick();
    chk("sat_done_once", done, 1'b0);
    chk("sat_q_empty", exp_q.size(), 0);

    // Backpressure during lane 1
    rd = {$urandom, $urandom_range(0, 255), $urandom, $urandom_range(256, 1000)};
    send(rd, 32'h0000_0300, 4'b1111);
    tick();                     // lane 0 accepted
    mem_ready = 1'b0;
    h_addr  = mem_addr;
    h_wdata = mem_wdata;
    chk("bp_lane1_addr", h_addr, 32'h0000_0301);
    for (int k = 0; k < 3; k++) begin
      chk("bp_hold_we", mem_we, 1'b1);
      chk("bp_hold_addr", mem_addr, h_addr);
      chk("bp_hold_wdata", mem_wdata, h_wdata);
      tick();
    end
    mem_ready = 1'b1;
    chk("bp_release_addr", mem_addr, h_addr);
    tick();                     // lane 1 accepted
    chk("bp_lane2_addr", mem_addr, 32'h0000_0302);
    tick();
    tick();
    chk("bp_done", done, 1'b1);
    tick();

    // Address wrap
    rd = {$urandom, $urandom, $urandom_range(0, 255), $urandom_range(0, 255)};
    send(rd, 32'hFFFF_FFFE, 4'b1111);
    for (int k = 1; k <= 4; k++) begin
      chk("wrap_we", mem_we, 1'b1);
      tick();
    end
    chk("wrap_done", done, 1'b1);
    tick();

    // Empty mask
    send(128'h1234_5678_9ABC_DEF0_0F0F_0F0F_F0F0_F0F0, 32'h0000_0400, 4'b0000);
    chk("empty_we", mem_we, 1'b0);
    chk("empty_done", done, 1'b1);
    chk("empty_busy", busy, 1'b1);
    chk("empty_in_ready_t1", in_ready, 1'b0);
    tick();
    chk("empty_in_ready_t2", in_ready, 1'b1);
    chk("empty_done_off", done, 1'b0);

    // Throughput: in_valid held high across two vectors
    rd = {$urandom, $urandom, $urandom, $urandom};
    in_data  = rd;
    in_addr  = 32'h0000_0500;
    in_mask  = 4'b0011;
    in_valid = 1'b1;
    push_vec(rd, 32'h0000_0500, 4'b0011);
    push_vec(rd, 32'h0000_0500, 4'b0011);
    chk("tp_ready_t0", in_ready, 1'b1);
    tick();                     // T
    chk("tp_ready_t1", in_ready, 1'b0);
    tick();
    tick();
    chk("tp_done", done, 1'b1);
    chk("tp_ready_t3", in_ready, 1'b0);
    tick();
    chk("tp_ready_t4", in_ready, 1'b1);
    tick();                     // second acceptance
    in_valid = 1'b0;
    chk("tp_second_busy", busy, 1'b1);
    chk("tp_second_we", mem_we, 1'b1);
    tick();
    tick();
    chk("tp_second_done", done, 1'b1);
    tick();
    chk("tp_q_empty", exp_q.size(), 0);

    // Reset after the lane 1 write
    rd = {$urandom, $urandom, $urandom, $urandom};
    send(rd, 32'h0000_0600, 4'b1111);
    tick();                     // lane 0
    tick();                     // lane 1
    chk("rst_mid_lane2_addr", mem_addr, 32'h0000_0602);
    void'(exp_q.pop_back());    // lanes 2 and 3 are dropped
    void'(exp_q.pop_back());
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle("rst_mid");
    for (int k = 0; k < 5; k++) begin
      chk("rst_mid_no_done", done, 1'b0);
      chk("rst_mid_no_we", mem_we, 1'b0);
      tick();
    end

    chk("final_q_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
